// File: rtl/chunk_arbiter_if.sv
// Requester-side bus of chunk_arbiter: per-VTU read pulses and addresses in,
// shared response data plus one-hot owner strobe out.
interface chunk_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 4
);
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_read_enable;
  logic [DATA_WIDTH-1:0]         resp_out;
  logic [NUM_REQ-1:0]            resp_valid;

  modport master (
    output req_addr, req_read_enable,
    input  resp_out, resp_valid
  );

  modport slave (
    input  req_addr, req_read_enable,
    output resp_out, resp_valid
  );
endinterface

// File: rtl/chunk_arbiter.sv
// Round-robin arbiter sharing one chunk memory among NUM_REQ VTUs, with a tag FIFO
// routing in-order read data back to its requester. Define CHUNK_ARB_STATS_EN for grant/stall counters.
module chunk_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  chunk_arbiter_if.slave        req_bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_out,
  input  logic                  mem_valid,
  output logic                  busy,
  output logic                  err_sticky
`ifdef CHUNK_ARB_STATS_EN
  ,
  output logic [31:0]           stat_grants,
  output logic [31:0]           stat_stall_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_REQ-1:0]    pending, pending_nxt;
  logic [ADDR_WIDTH-1:0] addr_q [NUM_REQ];
  logic [IDX_W-1:0]      rr_ptr, grant_idx;
  logic                  grant_found, do_grant, do_pop, dup_pulse, fifo_full;
  logic [IDX_W-1:0]      tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_count, fifo_count_nxt;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    return IDX_W'(sum % NUM_REQ);
  endfunction

  // A full FIFO may still take a grant when a response frees a slot in the same cycle.
  assign fifo_full = (fifo_count == CNT_W'(MAX_INFLIGHT));
  assign do_pop    = mem_valid && (fifo_count != '0);
  assign do_grant  = grant_found && (!fifo_full || do_pop);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && pending[wrap_idx(rr_ptr, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    pending_nxt = pending;
    dup_pulse   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_bus.req_read_enable[i]) begin
        if (pending[i]) dup_pulse = 1'b1;
        else            pending_nxt[i] = 1'b1;
      end
    end
    if (do_grant) pending_nxt[grant_idx] = 1'b0;
    fifo_count_nxt = fifo_count + CNT_W'(do_grant) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_bus.req_read_enable[i] && !pending[i])
        addr_q[i] <= req_bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
    if (do_grant) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending            <= '0;
      rr_ptr             <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_count         <= '0;
      mem_addr           <= '0;
      mem_read_enable    <= 1'b0;
      req_bus.resp_out   <= '0;
      req_bus.resp_valid <= '0;
      busy               <= 1'b0;
      err_sticky         <= 1'b0;
    end else begin
      pending         <= pending_nxt;
      fifo_count      <= fifo_count_nxt;
      mem_read_enable <= do_grant;
      if (do_grant) begin
        mem_addr <= addr_q[grant_idx];
        wr_ptr   <= wr_ptr + PTR_W'(1);
        rr_ptr   <= wrap_idx(grant_idx, 1);
      end
      if (do_pop) begin
        req_bus.resp_out   <= mem_out;
        req_bus.resp_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
        rd_ptr             <= rd_ptr + PTR_W'(1);
      end else begin
        req_bus.resp_valid <= '0;
      end
      // Duplicate pulses and data with no outstanding tag are both protocol violations.
      if (dup_pulse || (mem_valid && fifo_count == '0)) err_sticky <= 1'b1;
      busy <= (|pending_nxt) || (fifo_count_nxt != '0) || do_grant;
    end
  end

`ifdef CHUNK_ARB_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_grants       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (do_grant && stat_grants != '1) stat_grants <= stat_grants + 32'd1;
      if ((|pending) && !do_grant && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chunk_arbiter.sv
// Scoreboard bench for chunk_arbiter: expected issues/responses are queued at stimulus
// time and popped as the DUT issues reads and returns data through a behavioural chunk.
module tb_chunk_arbiter;
  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 4;
  localparam int MI = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_read_enable;
  logic [DW-1:0] mem_out;
  logic          mem_valid;
  logic          busy;
  logic          err_sticky;
`ifdef CHUNK_ARB_STATS_EN
  logic [31:0]   stat_grants;
  logic [31:0]   stat_stall_cycles;
`endif

  chunk_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  chunk_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_INFLIGHT(MI)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .req_bus(bus),
    .mem_addr(mem_addr),
    .mem_read_enable(mem_read_enable),
    .mem_out(mem_out),
    .mem_valid(mem_valid),
    .busy(busy),
    .err_sticky(err_sticky)
`ifdef CHUNK_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;
  int neg_cnt = 0;
  int issue_cnt = 0;
  int last_issue_cyc = -1;
  int last_resp_cyc = -1;
  int mv_cyc = -1;
  int mem_lat = 2;
  bit hold = 1'b0;
  int release_cnt = 0;
  bit stray_req = 1'b0;

  logic [AW-1:0]    exp_issue [$];
  logic [NR+DW-1:0] exp_resp [$];
  logic [AW-1:0]    pipe_addr [$];
  int               pipe_due [$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return a[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectRead(input int idx, input logic [AW-1:0] a);
    logic [NR-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    exp_issue.push_back(a);
    exp_resp.push_back({oh, data_of(a)});
  endtask

  task automatic applyStimulus(input logic [NR-1:0] mask, input logic [AW-1:0] a0,
                               input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic [AW-1:0] a3);
    bus.req_addr        = {a3, a2, a1, a0};
    bus.req_read_enable = mask;
    tick();
    bus.req_read_enable = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_issue.delete();
    exp_resp.delete();
    pipe_addr.delete();
    pipe_due.delete();
    hold = 1'b0;
    release_cnt = 0;
    stray_req = 1'b0;
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_mem_re", 32'(mem_read_enable), 32'h0);
    checkOutput("rst_resp_out", 32'(bus.resp_out), 32'h0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_err", 32'(err_sticky), 32'h0);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 100 && (exp_resp.size() != 0 || exp_issue.size() != 0); t++) tick();
    checkOutput({"drain_", tag}, 32'(exp_resp.size() + exp_issue.size()), 32'h0);
    repeat (3) tick();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor followed by the chunk model, both evaluated away from the active edge.
  initial forever begin
    @(negedge clk);
    neg_cnt++;
    if (!rst) begin
      if (mem_read_enable === 1'b1) begin
        issue_cnt++;
        last_issue_cyc = cyc;
        if (exp_issue.size() == 0) checkOutput("issue_unexpected", 32'(exp_issue.size()), 32'd1);
        else checkOutput("issue_addr", 32'(mem_addr), 32'(exp_issue.pop_front()));
        pipe_addr.push_back(mem_addr);
        pipe_due.push_back(neg_cnt + mem_lat);
      end
      if (bus.resp_valid !== '0) begin
        last_resp_cyc = cyc;
        if (exp_resp.size() == 0) checkOutput("resp_unexpected", 32'(bus.resp_valid), 32'h0);
        else checkOutput("resp_owner_data", 32'({bus.resp_valid, bus.resp_out}), 32'(exp_resp.pop_front()));
      end
    end
    mem_valid = 1'b0;
    if (stray_req) begin
      stray_req = 1'b0;
      mem_valid = 1'b1;
      mem_out   = 4'hF;
      mv_cyc    = cyc + 1;
    end else if (pipe_addr.size() > 0 && pipe_due[0] <= neg_cnt && (!hold || release_cnt > 0)) begin
      if (hold) release_cnt--;
      void'(pipe_due.pop_front());
      mem_valid = 1'b1;
      mem_out   = data_of(pipe_addr.pop_front());
      mv_cyc    = cyc + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pc;
    int ic0;
    bus.req_addr        = '0;
    bus.req_read_enable = '0;
    mem_valid           = 1'b0;
    mem_out             = '0;
    repeat (3) tick();
    doReset();

    // Single uncontended request: issue at +2, response at +5.
    pc = cyc;
    expectRead(2, 12'h123);
    applyStimulus(4'b0100, 12'h0, 12'h0, 12'h123, 12'h0);
    tick();
    checkOutput("single_busy_active", 32'(busy), 32'h1);
    repeat (10) tick();
    checkOutput("single_issue_lat", 32'(last_issue_cyc - pc), 32'd2);
    checkOutput("single_resp_lat", 32'(last_resp_cyc - pc), 32'd5);
    checkOutput("single_busy_idle", 32'(busy), 32'h0);
    checkOutput("single_drain", 32'(exp_resp.size()), 32'h0);

    // Round-robin bursts from rr_ptr=0, then rr_ptr=2 with {0,3} pending.
    doReset();
    pc = cyc;
    for (int i = 0; i < NR; i++) expectRead(i, 12'((i + 1) * 10));
    applyStimulus(4'b1111, 12'd10, 12'd20, 12'd30, 12'd40);
    drain("rr_burst1");
    checkOutput("rr_burst1_last_issue", 32'(last_issue_cyc - pc), 32'd5);
    expectRead(0, 12'h111); expectRead(1, 12'h222); expectRead(2, 12'h333); expectRead(3, 12'h444);
    applyStimulus(4'b1111, 12'h111, 12'h222, 12'h333, 12'h444);
    drain("rr_burst2");
    expectRead(1, 12'h055);
    applyStimulus(4'b0010, 12'h0, 12'h055, 12'h0, 12'h0);
    drain("rr_single1");
    expectRead(3, 12'h3C3); expectRead(0, 12'h0A0);
    applyStimulus(4'b1001, 12'h0A0, 12'h0, 12'h0, 12'h3C3);
    drain("rr_wrap");

    // Backpressure: chunk withholds data so the tag FIFO fills.
    doReset();
    hold = 1'b1;
    ic0 = issue_cnt;
    for (int i = 0; i < NR; i++) expectRead(i, 12'(12'h101 + i));
    applyStimulus(4'b1111, 12'h101, 12'h102, 12'h103, 12'h104);
    repeat (8) tick();
    checkOutput("bp_issues_full", 32'(issue_cnt - ic0), 32'd4);
    expectRead(0, 12'h505);
    applyStimulus(4'b0001, 12'h505, 12'h0, 12'h0, 12'h0);
    repeat (5) tick();
    checkOutput("bp_stalled", 32'(issue_cnt - ic0), 32'd4);
    checkOutput("bp_busy", 32'(busy), 32'h1);
    release_cnt = 1;
    for (int t = 0; t < 10 && (issue_cnt - ic0) < 5; t++) tick();
    checkOutput("bp_fifth_issue", 32'(issue_cnt - ic0), 32'd5);
    checkOutput("bp_push_with_pop", 32'(last_issue_cyc), 32'(mv_cyc));
    hold = 1'b0;
    drain("bp");
    checkOutput("bp_no_err", 32'(err_sticky), 32'h0);

    // Duplicate pulse keeps the first address; stray data is dropped.
    doReset();
    expectRead(1, 12'd5);
    applyStimulus(4'b0010, 12'h0, 12'd5, 12'h0, 12'h0);
    applyStimulus(4'b0010, 12'h0, 12'd9, 12'h0, 12'h0);
    drain("dup");
    checkOutput("dup_err", 32'(err_sticky), 32'h1);
    doReset();
    last_resp_cyc = -1;
    stray_req = 1'b1;
    repeat (4) tick();
    checkOutput("stray_err", 32'(err_sticky), 32'h1);
    checkOutput("stray_no_resp", 32'(last_resp_cyc), 32'hFFFF_FFFF);

    // Reset with 3 pending and 2 outstanding, then a fresh request.
    doReset();
    hold = 1'b1;
    expectRead(0, 12'h0A1); expectRead(1, 12'h0B2);
    applyStimulus(4'b0011, 12'h0A1, 12'h0B2, 12'h0, 12'h0);
    repeat (4) tick();
    applyStimulus(4'b1110, 12'h0, 12'h0C1, 12'h0C2, 12'h0C3);
    checkOutput("midrst_busy_before", 32'(busy), 32'h1);
    ic0 = issue_cnt;
    doReset();
    repeat (4) tick();
    checkOutput("midrst_no_issue", 32'(issue_cnt - ic0), 32'd0);
    checkOutput("midrst_busy_after", 32'(busy), 32'h0);
    expectRead(3, 12'h7AB);
    applyStimulus(4'b1000, 12'h0, 12'h0, 12'h0, 12'h7AB);
    drain("midrst_fresh");

`ifdef CHUNK_ARB_STATS_EN
    // Stall counting against a slow, withholding chunk.
    doReset();
    mem_lat = 3;
    hold = 1'b1;
    for (int i = 0; i < NR; i++) expectRead(i, 12'(12'h201 + i));
    applyStimulus(4'b1111, 12'h201, 12'h202, 12'h203, 12'h204);
    repeat (8) tick();
    expectRead(2, 12'h2EE);
    pc = cyc;
    ic0 = issue_cnt;
    applyStimulus(4'b0100, 12'h0, 12'h0, 12'h2EE, 12'h0);
    repeat (6) tick();
    release_cnt = 1;
    for (int t = 0; t < 10 && issue_cnt == ic0; t++) tick();
    hold = 1'b0;
    drain("stats");
    checkOutput("stat_grants", stat_grants, 32'd5);
    checkOutput("stat_stall_cycles", stat_stall_cycles, 32'(last_issue_cyc - pc - 2));
    mem_lat = 2;
`endif

    checkOutput("final_issue_q", 32'(exp_issue.size()), 32'h0);
    checkOutput("final_resp_q", 32'(exp_resp.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
